fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of writers.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO depth in entries.
REQ-004 SHALL have parameter CNT_W, default 4, FIFO count width.
REQ-005 SHALL have parameter MAX_BURST, default 4, beat limit per ownership when bursting is compiled in.
REQ-006 SHALL have port: clk  input  1  single clock, rising edge.
REQ-007 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port: req  input  NREQ  per-writer valid.
REQ-009 SHALL have port: din  input  NREQ*DW  per-writer data, writer i at bits [i*DW +: DW].
REQ-010 SHALL have port: gnt  output  NREQ  per-writer ready, at most one bit high.
REQ-011 SHALL have port: fifo_full  input  1  FIFO buf_full.
REQ-012 SHALL have port: fifo_cnt  input  CNT_W  FIFO occupancy.
REQ-013 SHALL have port: wr_en  output  1  FIFO push strobe, registered.
REQ-014 SHALL have port: buf_in  output  DW  FIFO push data, registered.
REQ-015 SHALL have port: busy  output  1  high while state is OWN.

Function
REQ-016 SHALL implement two states, IDLE and OWN, plus registers owner, rr_last and beat_cnt.
REQ-017 SHALL, in IDLE with any req bit high at an edge, load owner with the round-robin winner (search from rr_last+1 upward, wrapping) and enter OWN.
REQ-018 SHALL stay in IDLE while req is all zero; gnt stays zero in IDLE.
REQ-019 SHALL compute stall = fifo_full OR (fifo_cnt + wr_en >= DEPTH); this is conservative and ignores concurrent pops.
REQ-020 SHALL drive gnt[owner] = req[owner] AND NOT stall, combinationally in OWN; all other gnt bits are zero.
REQ-021 SHALL count a transfer at each edge where req[owner] and gnt[owner] are both high: buf_in <= din[owner], wr_en <= 1, beat_cnt increments.
REQ-022 SHALL drive wr_en low for one cycle after any edge without a transfer; buf_in holds its last value.
REQ-023 SHALL give a latency of exactly one cycle from the transfer edge to wr_en high with that beat on buf_in.
REQ-024 SHALL release ownership (OWN to IDLE, rr_last <= owner, beat_cnt <= 0) at the transfer edge whose beat reaches the burst limit.
REQ-025 SHALL also release ownership at any edge in OWN where req[owner] is low.
REQ-026 SHALL hold owner while stalled; a stall never releases ownership and never drops a beat.
REQ-027 SHALL never push into a full FIFO: with fifo_cnt = DEPTH-1 and wr_en high, gnt stays low.
REQ-028 SHALL NOT change owner when req of another writer changes mid-ownership.

Reset
REQ-029 SHALL, at an edge with rst high: state IDLE, wr_en 0, buf_in 0, beat_cnt 0, rr_last NREQ-1 (writer 0 wins first); gnt and busy then read 0.
REQ-030 SHALL discard a transfer coinciding with rst high; reset mid-burst aborts the burst with no partial push afterward.

Configuration
REQ-031 SHALL, with macro FIFO_ARB_BURST_EN defined, set the burst limit to MAX_BURST beats per ownership.
REQ-032 SHALL, without FIFO_ARB_BURST_EN, set the burst limit to 1 beat, with the beat_cnt register removed.

Structure
REQ-033 SHALL place the state encoding (IDLE/OWN) and the default parameter constants in package fifo_arb_pkg.
REQ-034 SHALL use one sub-module, rr_pick: a combinational round-robin picker taking req and rr_last and returning a winner index plus an any flag.

Verification
REQ-035 SHALL cover: reset then req=4'b0001, din0=8'h01 -> busy next cycle, gnt=0001, wr_en=1 with buf_in=01 one cycle after transfer.
REQ-036 SHALL cover: req=4'b1111 held, single-beat build -> owners 0,1,2,3,0 in order, each separated by an IDLE cycle.
REQ-037 SHALL cover: fifo_cnt=7, wr_en=1, DEPTH=8 -> gnt=0 and owner held; fifo_cnt drops to 6 with wr_en=0 -> gnt reasserts and the beat is pushed.
REQ-038 SHALL cover: FIFO_ARB_BURST_EN, writer 2 streams 10,20,30,40,50 with req high -> 10..40 pushed on consecutive cycles, release, 50 pushed in the next ownership.
REQ-039 SHALL cover: rst pulsed during the second beat of a burst -> wr_en 0 after the reset edge, no further push, writer 0 has priority afterward.
REQ-040 SHALL cover: fifo_full=1 with all req high for 20 cycles -> wr_en never high and gnt always 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
//   state_t   : arbiter FSM encoding (IDLE / OWN)
//   *_DEF     : default parameter values used by fifo_wr_arbiter and rr_pick
//   idx_w()   : width of an index into n items (minimum 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int CNT_W_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     [NREQ-1:0]  : request vector
//   rr_last [IDX_W-1:0] : index of the most recently served requester
//   winner  [IDX_W-1:0] : first requester found searching upward from rr_last+1, wrapping
//   any                 : at least one request bit is high
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [IDX_W-1:0] idx_c;

  // The scan starts one past the last winner, so the first hit is the fair choice.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx_c  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_c = IDX_W'((int'(rr_last) + i) % NREQ);
      if (!any && req[idx_c]) begin
        any    = 1'b1;
        winner = idx_c;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: grants one of NREQ writers ownership of a FIFO write port
// and forwards its beats as registered push strobes.
//   clk, rst            : clock, synchronous active-high reset
//   req  [NREQ-1:0]     : per-writer valid
//   din  [NREQ*DW-1:0]  : per-writer data, writer i at [i*DW +: DW]
//   gnt  [NREQ-1:0]     : per-writer ready (one-hot or zero)
//   fifo_full, fifo_cnt : FIFO status used for back-pressure
//   wr_en, buf_in       : registered FIFO push strobe and data
//   busy                : high while a writer owns the port
// Build option: define FIFO_ARB_BURST_EN to let an owner push up to MAX_BURST
// beats per ownership; otherwise every ownership is a single beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  input  logic               fifo_full,
  input  logic [CNT_W-1:0]   fifo_cnt,
  output logic               wr_en,
  output logic [DW-1:0]      buf_in,
  output logic               busy
);

  localparam int IDX_W = idx_w(NREQ);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, rr_last, pick_idx;
  logic             pick_any;
  logic [CNT_W:0]   occ_nxt;
  logic             stall, own_req, xfer, last_beat, release_own;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_last (rr_last),
    .winner  (pick_idx),
    .any     (pick_any)
  );

  // The beat pushed last cycle may not be visible in fifo_cnt yet, so count it.
  assign occ_nxt = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, wr_en};
  assign stall   = fifo_full | (int'(occ_nxt) >= DEPTH);
  assign own_req = req[owner];
  assign xfer    = (state == OWN) && own_req && !stall;
  assign busy    = (state == OWN);

`ifdef FIFO_ARB_BURST_EN
  localparam int BEAT_W = idx_w(MAX_BURST);
  logic [BEAT_W-1:0] beat_cnt;
  assign last_beat = (beat_cnt == BEAT_W'(MAX_BURST - 1));
`else
  assign last_beat = 1'b1;
`endif

  // A stall never releases; only the final beat or a dropped request does.
  assign release_own = (state == OWN) && ((xfer && last_beat) || !own_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = OWN;
      OWN:     if (release_own) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (xfer) gnt[owner] = 1'b1;
  end

  // p0 -> p1: control registers and the push strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_last <= IDX_W'(NREQ - 1);
      wr_en   <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      wr_en <= xfer;
      if (state == IDLE && pick_any) owner <= pick_idx;
      if (release_own) rr_last <= owner;
`ifdef FIFO_ARB_BURST_EN
      if (release_own)  beat_cnt <= '0;
      else if (xfer)    beat_cnt <= beat_cnt + 1'b1;
`endif
    end
  end

  // p0 -> p1: push data, held between transfers
  always_ff @(posedge clk) begin
    if (rst)       buf_in <= '0;
    else if (xfer) buf_in <= din[owner*DW +: DW];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
`ifdef FIFO_ARB_BURST_EN
  localparam int L = 4;
`else
  localparam int L = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    gnt;
  logic               fifo_full;
  logic [3:0]         fifo_cnt;
  logic               wr_en;
  logic [DW-1:0]      buf_in;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic         mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_cnt  (fifo_cnt),
    .wr_en     (wr_en),
    .buf_in    (buf_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every push seen on the FIFO side must match the oldest expected beat.
  always @(negedge clk) begin
    if (mon_en && wr_en !== 1'b0) begin
      logic [DW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_push wr_en=%b buf_in=%h required no push", wr_en, buf_in);
      end else begin
        e = exp_q.pop_front();
        if (wr_en !== 1'b1 || buf_in !== e) begin
          failures++;
          $display("FAIL push_data got=%h required=%h", buf_in, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; din = '0; fifo_full = 1'b0; fifo_cnt = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b required=0000", gnt); end
    checks++; if (wr_en !== 1'b0)  begin failures++; $display("FAIL reset_wr_en got=%b required=0", wr_en); end
    checks++; if (buf_in !== 8'h00) begin failures++; $display("FAIL reset_buf_in got=%h required=00", buf_in); end
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001; din[0 +: DW] = 8'h01;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt got=%b required=0000", gnt); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1)   begin failures++; $display("FAIL single_busy got=%b required=1", busy); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b required=0001", gnt); end
    exp_q.push_back(8'h01);
    tick();
    req = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== (L > 1)) begin failures++; $display("FAIL single_busy_after got=%b required=%b", busy, (L > 1)); end
    tick();
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL single_wr_en_drop got=%b required=0", wr_en); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL single_release got=%b required=0", busy); end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = 8'(8'hA0 + i);
    req = 4'b1111;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_idle_gnt got=%b required=0000", gnt); end
    for (int j = 0; j < 5*(L+1); j++) begin
      int slot, pos;
      logic [NREQ-1:0] eg;
      slot = j / (L+1);
      pos  = j % (L+1);
      eg   = (pos < L) ? 4'(1 << (slot % NREQ)) : 4'b0000;
      tick();
      @(negedge clk);
      checks++;
      if (gnt !== eg || busy !== (pos < L)) begin
        failures++;
        $display("FAIL rr_cycle%0d gnt=%b busy=%b required gnt=%b busy=%b", j, gnt, busy, eg, (pos < L));
      end
      if (pos < L) exp_q.push_back(8'(8'hA0 + (slot % NREQ)));
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    fifo_cnt = 4'd8; req = 4'b0100; din[2*DW +: DW] = 8'h5A;
    tick();
    @(negedge clk);
    req = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d gnt=%b busy=%b required gnt=0000 busy=1", c, gnt, busy);
      end
    end
    fifo_cnt = 4'd6;
    #2;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL stall_resume got=%b required=0100", gnt); end
    exp_q.push_back(8'h5A);
    tick();
    fifo_cnt = 4'd7;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL stall_cnt7_wr_en got=%b required=0000", gnt); end
    checks++; if (busy !== (L > 1)) begin failures++; $display("FAIL stall_owner_kept got=%b required=%b", busy, (L > 1)); end
    req = 4'b0000; fifo_cnt = 4'd0;
    tick();
    tick();
  endtask

  task automatic test_full;
    do_reset();
    fifo_full = 1'b1; req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || wr_en !== 1'b0) begin
        failures++;
        $display("FAIL full_cycle%0d gnt=%b wr_en=%b required gnt=0000 wr_en=0", c, gnt, wr_en);
      end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b required=1", busy); end
    req = 4'b0000; fifo_full = 1'b0;
    tick();
    tick();
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst;
    logic [DW-1:0] data [5];
    logic          eg   [6];
    int k;
    data[0] = 8'h10; data[1] = 8'h20; data[2] = 8'h30; data[3] = 8'h40; data[4] = 8'h50;
    eg[0] = 1; eg[1] = 1; eg[2] = 1; eg[3] = 1; eg[4] = 0; eg[5] = 1;
    do_reset();
    k = 0;
    req = 4'b0100; din[2*DW +: DW] = data[0];
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c > 0 && eg[c-1]) begin
        k++;
        din[2*DW +: DW] = data[k];
      end
      @(negedge clk);
      checks++;
      if (gnt !== (eg[c] ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL burst_gnt%0d got=%b required=%b", c, gnt, eg[c] ? 4'b0100 : 4'b0000);
      end
      if (c > 0) begin
        checks++;
        if (wr_en !== eg[c-1]) begin failures++; $display("FAIL burst_wr_en%0d got=%b required=%b", c, wr_en, eg[c-1]); end
      end
      if (eg[c]) exp_q.push_back(data[k]);
    end
    tick();
    req = 4'b0000;
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    do_reset();
    req = 4'b0100; din[2*DW +: DW] = 8'h10;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rstmid_first got=%b required=0100", gnt); end
    exp_q.push_back(8'h10);
    tick();
    din[2*DW +: DW] = 8'h20; din[0 +: DW] = 8'h77; din[3*DW +: DW] = 8'h33;
    req = 4'b1101; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0)   begin failures++; $display("FAIL rstmid_wr_en got=%b required=0", wr_en); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b required=0", busy); end
    checks++; if (buf_in !== 8'h00) begin failures++; $display("FAIL rstmid_buf_in got=%h required=00", buf_in); end
    tick();
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_priority got=%b required=0001", gnt); end
    exp_q.push_back(8'h77);
    tick();
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_full();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
